// File: rtl/vx_amo_sequencer.sv
// Round-robin read-modify-write sequencer sharing one AMO ALU between NUM_REQS requesters.
// One atomic operation in flight: read old word, compute, write back, return old word.

// Registered AMO ALU; opcodes are the RISC-V AMO funct5 encodings, anything else yields 0.
module VX_amo_alu_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [4:0]  op,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic [31:0] result
);
    logic [31:0] result_d;

    always_comb begin
        result_d = 32'h0;
        case (op)
            5'h00:   result_d = in1 + in2;
            5'h01:   result_d = in2;
            5'h04:   result_d = in1 ^ in2;
            5'h08:   result_d = in1 | in2;
            5'h0C:   result_d = in1 & in2;
            5'h10:   result_d = ($signed(in1) < $signed(in2)) ? in1 : in2;
            5'h14:   result_d = ($signed(in1) > $signed(in2)) ? in1 : in2;
            5'h18:   result_d = (in1 < in2) ? in1 : in2;
            5'h1C:   result_d = (in1 > in2) ? in1 : in2;
            default: result_d = 32'h0;
        endcase
    end

    // Only loaded in the ALU state so the write data holds across a write stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result <= 32'h0;
        end else if (enable) begin
            result <= result_d;
        end
    end
endmodule

module vx_amo_sequencer #(
    parameter int unsigned NUM_REQS = 4,
    parameter int unsigned TAGW     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQS-1:0]      req_valid,
    input  logic [NUM_REQS*5-1:0]    req_op,
    input  logic [NUM_REQS*32-1:0]   req_addr,
    input  logic [NUM_REQS*32-1:0]   req_data,
    input  logic [NUM_REQS*TAGW-1:0] req_tag,
    output logic [NUM_REQS-1:0]      req_ready,
    output logic [NUM_REQS-1:0]      rsp_valid,
    output logic [31:0]              rsp_data,
    output logic [TAGW-1:0]          rsp_tag,
    input  logic [NUM_REQS-1:0]      rsp_ready,
    output logic                     mem_req_valid,
    output logic                     mem_req_rw,
    output logic [31:0]              mem_req_addr,
    output logic [31:0]              mem_req_data,
    input  logic                     mem_req_ready,
    input  logic                     mem_rsp_valid,
    input  logic [31:0]              mem_rsp_data,
    output logic                     busy
);
    localparam int unsigned IdxW = $clog2(NUM_REQS);

    typedef enum logic [2:0] {
        StIdle, StRdReq, StRdWait, StAlu, StWrReq, StWrWait, StRsp
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   last_q, idx_q;
    logic [4:0]        op_q;
    logic [31:0]       addr_q, data_q, old_q;
    logic [TAGW-1:0]   tag_q;
    logic [31:0]       alu_result;

    logic              found;
    logic [IdxW-1:0]   grant_idx;
    logic [NUM_REQS-1:0] grant;
    logic [4:0]        grant_op;
    logic [31:0]       grant_addr, grant_data;
    logic [TAGW-1:0]   grant_tag;
    int unsigned       cand;
    logic [IdxW-1:0]   cand_idx;

    // Search starts one past the last winner and wraps.
    always_comb begin
        found      = 1'b0;
        grant_idx  = '0;
        grant      = '0;
        grant_op   = '0;
        grant_addr = '0;
        grant_data = '0;
        grant_tag  = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQS; k++) begin
            cand = 32'(last_q) + k;
            if (cand >= NUM_REQS) begin
                cand = cand - NUM_REQS;
            end
            cand_idx = cand[IdxW-1:0];
            if (!found && req_valid[cand_idx]) begin
                found     = 1'b1;
                grant_idx = cand_idx;
            end
        end
        for (int unsigned j = 0; j < NUM_REQS; j++) begin
            if (found && grant_idx == IdxW'(j)) begin
                grant[j]   = 1'b1;
                grant_op   = req_op[j*5 +: 5];
                grant_addr = req_addr[j*32 +: 32];
                grant_data = req_data[j*32 +: 32];
                grant_tag  = req_tag[j*TAGW +: TAGW];
            end
        end
    end

    assign req_ready = (state_q == StIdle) ? grant : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (found)              state_d = StRdReq;
            StRdReq:  if (mem_req_ready)      state_d = StRdWait;
            StRdWait: if (mem_rsp_valid)      state_d = StAlu;
            StAlu:                            state_d = StWrReq;
            StWrReq:  if (mem_req_ready)      state_d = StWrWait;
            StWrWait: if (mem_rsp_valid)      state_d = StRsp;
            StRsp:    if (rsp_ready[idx_q])   state_d = StIdle;
            default:                          state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= IdxW'(NUM_REQS - 1);
            idx_q  <= '0;
            op_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
            tag_q  <= '0;
            old_q  <= '0;
        end else begin
            if (state_q == StIdle && found) begin
                last_q <= grant_idx;
                idx_q  <= grant_idx;
                op_q   <= grant_op;
                addr_q <= grant_addr;
                data_q <= grant_data;
                tag_q  <= grant_tag;
            end
            if (state_q == StRdWait && mem_rsp_valid) begin
                old_q <= mem_rsp_data;
            end
        end
    end

    VX_amo_alu_unit u_alu (
        .clk    (clk),
        .reset  (reset),
        .enable (state_q == StAlu),
        .op     (op_q),
        .in1    (old_q),
        .in2    (data_q),
        .result (alu_result)
    );

    always_comb begin
        rsp_valid = '0;
        if (state_q == StRsp) begin
            rsp_valid[idx_q] = 1'b1;
        end
    end

    assign rsp_data      = (state_q == StRsp) ? old_q : 32'h0;
    assign rsp_tag       = (state_q == StRsp) ? tag_q : '0;
    assign mem_req_valid = (state_q == StRdReq) || (state_q == StWrReq);
    assign mem_req_rw    = (state_q == StWrReq);
    assign mem_req_addr  = mem_req_valid ? addr_q : 32'h0;
    assign mem_req_data  = (state_q == StWrReq) ? alu_result : 32'h0;
    assign busy          = (state_q != StIdle);
endmodule

// File: tb/tb_vx_amo_sequencer.sv
// Directed bench for vx_amo_sequencer: per-scenario tasks with a cycle-driven memory responder.
module tb_vx_amo_sequencer;
    localparam int NR = 4;
    localparam int TW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*5-1:0] req_op = '0;
    logic [NR*32-1:0] req_addr = '0;
    logic [NR*32-1:0] req_data = '0;
    logic [NR*TW-1:0] req_tag = '0;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   rsp_valid;
    logic [31:0]     rsp_data;
    logic [TW-1:0]   rsp_tag;
    logic [NR-1:0]   rsp_ready = '0;
    logic            mem_req_valid, mem_req_rw;
    logic [31:0]     mem_req_addr, mem_req_data;
    logic            mem_req_ready = 1'b0;
    logic            mem_rsp_valid = 1'b0;
    logic [31:0]     mem_rsp_data = '0;
    logic            busy;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] mem [0:255];

    typedef struct packed {
        logic [NR-1:0] grant;
        int            acc_cyc;
        logic [31:0]   rd_addr;
        int            rd_cyc;
        logic [31:0]   wr_addr;
        logic [31:0]   wr_data;
        int            wr_cyc;
        logic [NR-1:0] rsp_vec;
        logic [31:0]   rsp_data;
        logic [TW-1:0] rsp_tag;
        int            rsp_cyc;
        int            n_rd;
        int            n_wr;
        bit            unstable;
        bit            timeout;
    } res_t;

    vx_amo_sequencer #(.NUM_REQS(NR), .TAGW(TW)) dut (
        .clk           (clk),
        .reset         (rst_n),
        .req_valid     (req_valid),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_tag       (req_tag),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_tag       (rsp_tag),
        .rsp_ready     (rsp_ready),
        .mem_req_valid (mem_req_valid),
        .mem_req_rw    (mem_req_rw),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0; rsp_ready = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] op,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [TW-1:0] tag);
        req_valid[i]         = v;
        req_op[i*5 +: 5]     = op;
        req_addr[i*32 +: 32] = addr;
        req_data[i*32 +: 32] = data;
        req_tag[i*TW +: TW]  = tag;
    endtask

    // Drives memory and response handshakes cycle by cycle; cycle 0 is the accept cycle.
    task automatic run_seq(input int rd_stall, input int wr_stall, input int rsp_stall,
                           input bit drop, output res_t r);
        bit pend, done, req_hold, rsp_hold;
        logic [31:0] pend_data;
        logic [65:0] req_snap;
        logic [NR+TW+31:0] rsp_snap;
        int rd_cnt, wr_cnt, rsp_cnt;
        r = '0;
        r.acc_cyc = -1; r.rd_cyc = -1; r.wr_cyc = -1; r.rsp_cyc = -1;
        pend = 0; done = 0; req_hold = 0; rsp_hold = 0; pend_data = '0;
        req_snap = '0; rsp_snap = '0; rd_cnt = 0; wr_cnt = 0; rsp_cnt = 0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            mem_rsp_valid = pend;
            mem_rsp_data  = pend ? pend_data : 32'hDEAD_BEEF;
            pend = 0;
            mem_req_ready = 1'b0;
            if (mem_req_valid) mem_req_ready = mem_req_rw ? (wr_cnt >= wr_stall)
                                                          : (rd_cnt >= rd_stall);
            // Non-target ready bits stay high during the stall; they must be ignored.
            rsp_ready = (rsp_cnt >= rsp_stall) ? '1 : ~rsp_valid;
            #1;
            if (req_hold && req_snap !== {mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data})
                r.unstable = 1;
            if (rsp_hold && rsp_snap !== {rsp_valid, rsp_tag, rsp_data}) r.unstable = 1;
            if ((req_valid & req_ready) != '0) begin
                r.grant = req_valid & req_ready;
                r.acc_cyc = cyc;
            end
            if (mem_req_valid && mem_req_ready) begin
                pend = 1;
                if (mem_req_rw) begin
                    r.n_wr++; r.wr_addr = mem_req_addr; r.wr_data = mem_req_data; r.wr_cyc = cyc;
                    mem[mem_req_addr[7:0]] = mem_req_data;
                    pend_data = 32'hDEAD_BEEF;
                end else begin
                    r.n_rd++; r.rd_addr = mem_req_addr; r.rd_cyc = cyc;
                    pend_data = mem[mem_req_addr[7:0]];
                end
            end else if (mem_req_valid) begin
                if (mem_req_rw) wr_cnt++;
                else rd_cnt++;
            end
            req_hold = mem_req_valid && !mem_req_ready;
            req_snap = {mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data};
            if ((rsp_valid & rsp_ready) != '0) begin
                r.rsp_vec = rsp_valid; r.rsp_data = rsp_data; r.rsp_tag = rsp_tag;
                r.rsp_cyc = cyc;
                done = 1;
            end else if (rsp_valid != '0) begin
                rsp_cnt++;
            end
            rsp_hold = (rsp_valid != '0) && ((rsp_valid & rsp_ready) == '0);
            rsp_snap = {rsp_valid, rsp_tag, rsp_data};
            @(posedge clk);
            #1;
            if (drop && r.acc_cyc == cyc) req_valid = req_valid & ~r.grant;
        end
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; rsp_ready = '0;
        if (!done) r.timeout = 1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if ({mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data} !== 66'h0) begin
            n_bad++; $display("FAIL reset_mem_req: got %b %b %h %h want all 0", mem_req_valid,
                              mem_req_rw, mem_req_addr, mem_req_data); end
        n_vec++; if ({rsp_valid, rsp_data, rsp_tag} !== '0) begin
            n_bad++; $display("FAIL reset_rsp: got %b %h %h want all 0", rsp_valid, rsp_data,
                              rsp_tag); end
        n_vec++; if (req_ready !== 4'b0000) begin
            n_bad++; $display("FAIL reset_req_ready_idle: got %b want 0000", req_ready); end
        req_valid = 4'b1111;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin
            n_bad++; $display("FAIL reset_first_priority: got %b want 0001", req_ready); end
        req_valid = 4'b0000;
        #1;
    endtask

    task automatic test_add();
        res_t r;
        mem[8'h40] = 32'd5;
        set_req(0, 1'b1, 5'h00, 32'h40, 32'd3, 8'h11);
        run_seq(0, 0, 0, 1'b1, r);
        n_vec++; if (r.timeout) begin n_bad++; $display("FAIL add_timeout: got timeout want done"); end
        n_vec++; if (r.grant !== 4'b0001 || r.acc_cyc != 0) begin
            n_bad++; $display("FAIL add_accept: got %b@%0d want 0001@0", r.grant, r.acc_cyc); end
        n_vec++; if (r.rd_addr !== 32'h40 || r.rd_cyc != 1) begin
            n_bad++; $display("FAIL add_read: got %h@%0d want 40@1", r.rd_addr, r.rd_cyc); end
        n_vec++; if (r.wr_addr !== 32'h40 || r.wr_data !== 32'd8 || r.wr_cyc != 4) begin
            n_bad++; $display("FAIL add_write: got %h=%h@%0d want 40=8@4", r.wr_addr, r.wr_data,
                              r.wr_cyc); end
        n_vec++; if (r.rsp_vec !== 4'b0001 || r.rsp_cyc != 6) begin
            n_bad++; $display("FAIL add_rsp_timing: got %b@%0d want 0001@6", r.rsp_vec, r.rsp_cyc); end
        n_vec++; if (r.rsp_data !== 32'd5 || r.rsp_tag !== 8'h11) begin
            n_bad++; $display("FAIL add_rsp_payload: got %h/%h want 5/11", r.rsp_data, r.rsp_tag); end
    endtask

    task automatic test_ops();
        logic [4:0]  ops [12] = '{5'h10, 5'h18, 5'h14, 5'h1C, 5'h01, 5'h04, 5'h08, 5'h0C,
                                  5'h00, 5'h1F, 5'h02, 5'h03};
        logic [31:0] mv [12] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'h1234, 32'hF0F0, 32'hF000, 32'hFF00, 32'hFFFF_FFFF,
                                 32'd7, 32'd7, 32'd7};
        logic [31:0] dv [12] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'hABCD, 32'h0FF0, 32'h000F,
                                 32'h0FF0, 32'd2, 32'd9, 32'd9, 32'd9};
        logic [31:0] ev [12] = '{32'hFFFF_FFFF, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hABCD, 32'hFF00,
                                 32'hF00F, 32'h0F00, 32'd1, 32'd0, 32'd0, 32'd0};
        res_t r;
        for (int k = 0; k < 12; k++) begin
            logic [31:0]   a;
            logic [TW-1:0] t;
            logic [NR-1:0] oh;
            a  = 32'h10 + k;
            t  = 8'h30 + 8'(k);
            oh = 4'b0001 << (k % 4);
            mem[a[7:0]] = mv[k];
            set_req(k % 4, 1'b1, ops[k], a, dv[k], t);
            run_seq(0, 0, 0, 1'b1, r);
            n_vec++; if (r.timeout || r.grant !== oh || r.rsp_vec !== oh) begin
                n_bad++; $display("FAIL op%0d_grant: got %b/%b to=%0d want %b", k, r.grant,
                                  r.rsp_vec, r.timeout, oh); end
            n_vec++; if (r.rd_addr !== a || r.wr_addr !== a) begin
                n_bad++; $display("FAIL op%0d_addr: got %h/%h want %h", k, r.rd_addr, r.wr_addr, a); end
            n_vec++; if (r.wr_data !== ev[k]) begin
                n_bad++; $display("FAIL op%0d_wdata: got %h want %h", k, r.wr_data, ev[k]); end
            n_vec++; if (r.rsp_data !== mv[k] || r.rsp_tag !== t) begin
                n_bad++; $display("FAIL op%0d_rsp: got %h/%h want %h/%h", k, r.rsp_data, r.rsp_tag,
                                  mv[k], t); end
        end
    endtask

    task automatic test_stalls();
        res_t r;
        mem[8'h60] = 32'd100;
        set_req(3, 1'b1, 5'h00, 32'h60, 32'd23, 8'h5A);
        run_seq(3, 3, 4, 1'b1, r);
        n_vec++; if (r.timeout || r.unstable) begin
            n_bad++; $display("FAIL stall_stable: got to=%0d unstable=%0d want 0/0", r.timeout,
                              r.unstable); end
        n_vec++; if (r.n_rd != 1 || r.n_wr != 1) begin
            n_bad++; $display("FAIL stall_counts: got rd=%0d wr=%0d want 1/1", r.n_rd, r.n_wr); end
        n_vec++; if (r.rd_cyc != 4 || r.wr_cyc != 10 || r.rsp_cyc != 16) begin
            n_bad++; $display("FAIL stall_timing: got %0d/%0d/%0d want 4/10/16", r.rd_cyc, r.wr_cyc,
                              r.rsp_cyc); end
        n_vec++; if (r.wr_data !== 32'd123 || r.rsp_data !== 32'd100 || r.rsp_vec !== 4'b1000) begin
            n_bad++; $display("FAIL stall_data: got %h/%h/%b want 7b/64/1000", r.wr_data,
                              r.rsp_data, r.rsp_vec); end
        n_vec++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
            n_bad++; $display("FAIL stall_single_rsp: got %b busy=%b want 0000 busy=0", rsp_valid,
                              busy); end
    endtask

    task automatic test_round_robin();
        int exp_g [5] = '{0, 1, 2, 3, 0};
        res_t r;
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 5'h00, 32'h20 + i, i + 1, 8'h40 + 8'(i));
        for (int n = 0; n < 5; n++) begin
            run_seq(0, 0, 0, 1'b0, r);
            n_vec++; if (r.timeout || r.grant !== (4'b0001 << exp_g[n]) || r.acc_cyc != 0) begin
                n_bad++; $display("FAIL rr%0d_grant: got %b@%0d want %b@0", n, r.grant, r.acc_cyc,
                                  4'b0001 << exp_g[n]); end
            n_vec++; if (r.rsp_tag !== 8'h40 + 8'(exp_g[n])) begin
                n_bad++; $display("FAIL rr%0d_tag: got %h want %h", n, r.rsp_tag,
                                  8'h40 + 8'(exp_g[n])); end
        end
        req_valid = 4'b0100;
        run_seq(0, 0, 0, 1'b0, r);
        n_vec++; if (r.grant !== 4'b0100) begin
            n_bad++; $display("FAIL rr_only2: got %b want 0100", r.grant); end
        req_valid = 4'b0101;
        run_seq(0, 0, 0, 1'b0, r);
        n_vec++; if (r.grant !== 4'b0001) begin
            n_bad++; $display("FAIL rr_wrap_to0: got %b want 0001", r.grant); end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        res_t r;
        mem[8'h80] = 32'h10;
        set_req(0, 1'b1, 5'h00, 32'h80, 32'd1, 8'h22);
        mem_req_ready = 1'b1; rsp_ready = '1;
        tick();                                  // RD_REQ
        req_valid = '0;
        tick();                                  // RD_WAIT
        mem_rsp_valid = 1'b1; mem_rsp_data = mem[8'h80];
        tick();                                  // ALU
        mem_rsp_valid = 1'b0;
        tick();                                  // WR_REQ
        n_vec++; if (!mem_req_valid || !mem_req_rw || mem_req_data !== 32'h11) begin
            n_bad++; $display("FAIL mid_write: got v=%b rw=%b d=%h want 1/1/11", mem_req_valid,
                              mem_req_rw, mem_req_data); end
        tick();                                  // WR_WAIT, ack withheld
        n_vec++; if (busy !== 1'b1 || mem_req_valid !== 1'b0) begin
            n_bad++; $display("FAIL mid_wrwait: got busy=%b v=%b want 1/0", busy, mem_req_valid); end
        mem_req_ready = 1'b0; rsp_ready = '0;
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if ({busy, mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, rsp_valid,
                      rsp_data, rsp_tag, req_ready} !== '0) begin
            n_bad++; $display("FAIL mid_reset_outputs: got busy=%b v=%b a=%h d=%h rv=%b want 0",
                              busy, mem_req_valid, mem_req_addr, mem_req_data, rsp_valid); end
        tick();
        rst_n = 1'b1;
        set_req(1, 1'b1, 5'h00, 32'h84, 32'd2, 8'h77);
        set_req(0, 1'b1, 5'h00, 32'h80, 32'd1, 8'h66);
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin
            n_bad++; $display("FAIL mid_priority: got %b want 0001", req_ready); end
        mem[8'h84] = 32'd40;
        run_seq(0, 0, 0, 1'b1, r);
        n_vec++; if (r.grant !== 4'b0001 || r.rsp_data !== 32'h10 || r.wr_data !== 32'h11) begin
            n_bad++; $display("FAIL mid_after_req0: got %b %h %h want 0001 10 11", r.grant,
                              r.rsp_data, r.wr_data); end
        run_seq(0, 0, 0, 1'b1, r);
        n_vec++; if (r.grant !== 4'b0010 || r.rsp_tag !== 8'h77 || r.wr_data !== 32'd42) begin
            n_bad++; $display("FAIL mid_after_req1: got %b %h %h want 0010 77 2a", r.grant,
                              r.rsp_tag, r.wr_data); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_add();
        test_ops();
        test_stalls();
        test_round_robin();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000");
        $fatal(1, "watchdog expired");
    end
endmodule
